// File: rtl/cellrv32_onewire_dev_pkg.sv
// -----------------------------------------------------------------------------
// cellrv32_package (1-Wire device slice)
// Shared address map and FSM state type for the 1-Wire device controller.
//   onewire_dev_base_c      : base address of the register window
//   onewire_dev_size_c      : window size in bytes (two 32-bit registers)
//   onewire_dev_ctrl_addr_c : CTRL register address
//   onewire_dev_data_addr_c : DATA register address
// -----------------------------------------------------------------------------
package cellrv32_package;

  localparam logic [31:0] onewire_dev_base_c      = 32'hFFFF_FF60;
  localparam int          onewire_dev_size_c      = 8;
  localparam logic [31:0] onewire_dev_ctrl_addr_c = onewire_dev_base_c;
  localparam logic [31:0] onewire_dev_data_addr_c = onewire_dev_base_c + 32'd4;

  typedef enum logic [2:0] {
    OFFLINE    = 3'd0,
    IDLE       = 3'd1,
    ACTIVE     = 3'd2,
    PRES_WAIT  = 3'd3,
    PRES_DRIVE = 3'd4
  } ow_state_t;

endpackage

// File: rtl/cellrv32_onewire_dev_tickgen.sv
// -----------------------------------------------------------------------------
// cellrv32_onewire_dev_tickgen
// Base time tick for the 1-Wire device, same scheme as the host controller:
// the selected clock-generator enable is divided by clkdiv+1.
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   en_i      : module enable; the divider counter is held at 0 while low
//   prsc_i    : selects one of clkgen_i[3:0]
//   clkdiv_i  : divider value (tick every clkdiv+1 selected enables)
//   clkgen_i  : clock generator enables
//   tick_o    : one-cycle base tick
//   tick_ff_o : tick_o delayed by one cycle
// -----------------------------------------------------------------------------
module cellrv32_onewire_dev_tickgen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] prsc_i,
  input  logic [7:0] clkdiv_i,
  input  logic [3:0] clkgen_i,
  output logic       tick_o,
  output logic       tick_ff_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;
  logic       tick_ff_q, tick_ff_d;
  logic       clk_sel;

  always_comb begin
    clk_sel   = clkgen_i[prsc_i];
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    tick_ff_d = tick_q;
    if (!en_i) begin
      cnt_d = 8'd0;
    end else if (clk_sel) begin
      if (cnt_q == clkdiv_i) begin
        cnt_d  = 8'd0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= 8'd0;
      tick_q    <= 1'b0;
      tick_ff_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      tick_ff_q <= tick_ff_d;
    end
  end

  assign tick_o    = tick_q;
  assign tick_ff_o = tick_ff_q;

endmodule

// File: rtl/cellrv32_onewire_dev.sv
// -----------------------------------------------------------------------------
// cellrv32_onewire_dev
// 1-Wire bus *device* (slave) with a two-register bus interface.
// Receives/transmits bytes LSB first in host-timed slots, detects host reset
// pulses and optionally answers with a presence pulse.
//   clk_i/rst_i      : clock, asynchronous active-high reset
//   addr_i, rden_i, wren_i, data_i, data_o, ack_o : register bus
//   clkgen_en_o      : request for the SoC clock generator (= en)
//   clkgen_i[3:0]    : clock generator enables (prescaler taps)
//   onewire_i        : bus line state
//   onewire_o        : bus pull-down (0 = pull low, 1 = release)
//   irq_o            : single-cycle pulse on byte done or reset detected
// Registers: CTRL (+0): [0] en, [2:1] prsc, [10:3] clkdiv, [11] pres_en,
//   [12] arm_rx (wo), [13] arm_tx (wo), [28] rst_seen (w1c), [29] sense,
//   [30] armed, [31] busy.  DATA (+4): write tx_data, read shift register.
// -----------------------------------------------------------------------------
module cellrv32_onewire_dev (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        clkgen_en_o,
  input  logic [7:0]  clkgen_i,
  input  logic        onewire_i,
  output logic        onewire_o,
  output logic        irq_o
);

  import cellrv32_package::*;

  // slot timing in base ticks
  localparam logic [6:0] t_sample     = 7'd3;
  localparam logic [6:0] t_tx_release = 7'd4;
  localparam logic [6:0] t_reset_min  = 7'd40;
  localparam logic [6:0] t_pres_wait  = 7'd2;
  localparam logic [6:0] t_pres_len   = 7'd12;

  logic        en_q, en_d;
  logic [1:0]  prsc_q, prsc_d;
  logic [7:0]  clkdiv_q, clkdiv_d;
  logic        pres_en_q, pres_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  sreg_q, sreg_d;
  logic        rst_seen_q, rst_seen_d;
  logic        armed_q, armed_d;
  logic        tx_mode_q, tx_mode_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  tick_cnt_q, tick_cnt_d;
  ow_state_t   state_q, state_d;
  logic        drive_q, drive_d;
  logic [1:0]  sync_q, sync_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic tick, tick_ff;
  logic addr_match, acc_ctrl, acc_data;
  logic line, fall, busy;
  logic unused_bits;

  cellrv32_onewire_dev_tickgen u_tickgen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_q),
    .prsc_i    (prsc_q),
    .clkdiv_i  (clkdiv_q),
    .clkgen_i  (clkgen_i[3:0]),
    .tick_o    (tick),
    .tick_ff_o (tick_ff)
  );

  assign addr_match = (addr_i[31:3] == onewire_dev_base_c[31:3]);
  assign acc_ctrl   = addr_match & ~addr_i[2];
  assign acc_data   = addr_match &  addr_i[2];

  // sync_q[0] is the current synchronized level, sync_q[1] the previous one
  assign line = sync_q[0];
  assign fall = sync_q[1] & ~sync_q[0];
  assign busy = (state_q != IDLE) && (state_q != OFFLINE);

  assign unused_bits = &{1'b0, clkgen_i[7:4], addr_i[1:0], data_i[31:29], data_i[27:14]};

  always_comb begin
    en_d       = en_q;
    prsc_d     = prsc_q;
    clkdiv_d   = clkdiv_q;
    pres_en_d  = pres_en_q;
    tx_data_d  = tx_data_q;
    sreg_d     = sreg_q;
    rst_seen_d = rst_seen_q;
    armed_d    = armed_q;
    tx_mode_d  = tx_mode_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    state_d    = state_q;
    drive_d    = drive_q;
    sync_d     = {sync_q[0], onewire_i};
    irq_d      = 1'b0;
    ack_d      = (rden_i | wren_i) & (acc_ctrl | acc_data);
    rdata_d    = 32'd0;

    // ---- bus read ----
    if (rden_i && acc_ctrl) begin
      rdata_d = {busy, armed_q, line, rst_seen_q, 16'd0,
                 pres_en_q, clkdiv_q, prsc_q, en_q};
    end else if (rden_i && acc_data) begin
      rdata_d = {24'd0, sreg_q};
    end

    // ---- bus write; FSM below may override (reset event wins over clear) ----
    if (wren_i && acc_ctrl) begin
      en_d      = data_i[0];
      prsc_d    = data_i[2:1];
      clkdiv_d  = data_i[10:3];
      pres_en_d = data_i[11];
      if (data_i[28]) begin
        rst_seen_d = 1'b0;
      end
      if (!busy) begin
        if (data_i[13]) begin
          armed_d   = 1'b1;
          tx_mode_d = 1'b1;
          sreg_d    = tx_data_q;
        end else if (data_i[12]) begin
          armed_d   = 1'b1;
          tx_mode_d = 1'b0;
        end
      end
    end
    if (wren_i && acc_data) begin
      tx_data_d = data_i[7:0];
    end

    // ---- bus FSM ----
    case (state_q)
      OFFLINE: begin
        sreg_d    = 8'd0;
        armed_d   = 1'b0;
        bit_cnt_d = 3'd7;
        drive_d   = 1'b1;
        if (en_q) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        drive_d = 1'b1;
        if (fall) begin
          tick_cnt_d = 7'd0;
          state_d    = ACTIVE;
          // a transmitted 0 is sent by stretching the host's low phase
          if (armed_q && tx_mode_q && !sreg_q[0]) begin
            drive_d = 1'b0;
          end
        end
      end

      ACTIVE: begin
        if (tick && (tick_cnt_q != 7'd127)) begin
          tick_cnt_d = tick_cnt_q + 7'd1;
        end
        // tick_ff is high only in the first cycle after the counter stepped,
        // so this fires exactly once per slot
        if (armed_q && tick_ff && (tick_cnt_q == t_sample)) begin
          sreg_d = {(tx_mode_q ? 1'b0 : line), sreg_q[7:1]};
          if (bit_cnt_q == 3'd0) begin
            irq_d     = 1'b1;
            armed_d   = 1'b0;
            bit_cnt_d = 3'd7;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
        if (tx_mode_q && (tick_cnt_q >= t_tx_release)) begin
          drive_d = 1'b1;
        end
        if (line && (tick_cnt_q >= t_tx_release)) begin
          if (tick_cnt_q >= t_reset_min) begin
            rst_seen_d = 1'b1;
            irq_d      = 1'b1;
            armed_d    = 1'b0;
            bit_cnt_d  = 3'd7;
            tick_cnt_d = 7'd0;
            state_d    = pres_en_q ? PRES_WAIT : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      PRES_WAIT: begin
        if (tick) begin
          if (tick_cnt_q == (t_pres_wait - 7'd1)) begin
            tick_cnt_d = 7'd0;
            drive_d    = 1'b0;
            state_d    = PRES_DRIVE;
          end else begin
            tick_cnt_d = tick_cnt_q + 7'd1;
          end
        end
      end

      PRES_DRIVE: begin
        drive_d = 1'b0;
        if (tick) begin
          if (tick_cnt_q == (t_pres_len - 7'd1)) begin
            tick_cnt_d = 7'd0;
            drive_d    = 1'b1;
            state_d    = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 7'd1;
          end
        end
      end

      default: begin
        state_d = OFFLINE;
      end
    endcase

    // disabled device: drop everything immediately
    if (!en_q) begin
      state_d    = OFFLINE;
      sreg_d     = 8'd0;
      armed_d    = 1'b0;
      bit_cnt_d  = 3'd7;
      tick_cnt_d = 7'd0;
      drive_d    = 1'b1;
      irq_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      prsc_q     <= 2'd0;
      clkdiv_q   <= 8'd0;
      pres_en_q  <= 1'b0;
      tx_data_q  <= 8'd0;
      sreg_q     <= 8'd0;
      rst_seen_q <= 1'b0;
      armed_q    <= 1'b0;
      tx_mode_q  <= 1'b0;
      bit_cnt_q  <= 3'd7;
      tick_cnt_q <= 7'd0;
      state_q    <= OFFLINE;
      drive_q    <= 1'b1;
      sync_q     <= 2'b11;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      prsc_q     <= prsc_d;
      clkdiv_q   <= clkdiv_d;
      pres_en_q  <= pres_en_d;
      tx_data_q  <= tx_data_d;
      sreg_q     <= sreg_d;
      rst_seen_q <= rst_seen_d;
      armed_q    <= armed_d;
      tx_mode_q  <= tx_mode_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      drive_q    <= drive_d;
      sync_q     <= sync_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign data_o      = rdata_q;
  assign ack_o       = ack_q;
  assign irq_o       = irq_q;
  assign clkgen_en_o = en_q;
  // en_q clears on the write edge (or asynchronously on reset), so the line
  // is released without waiting for the FSM to reach OFFLINE
  assign onewire_o   = drive_q | ~en_q;

endmodule

// File: tb/tb_cellrv32_onewire_dev.sv
// -----------------------------------------------------------------------------
// Directed bench for cellrv32_onewire_dev. The host side of the 1-Wire bus is
// modelled as an open-drain driver wired-AND with the device pull-down.
// Base tick: prsc=0, clkdiv=4 with clkgen_i all ones -> one tick per 5 cycles.
// -----------------------------------------------------------------------------
module tb_cellrv32_onewire_dev;

  import cellrv32_package::*;

  localparam logic [31:0] CTRL = onewire_dev_ctrl_addr_c;
  localparam logic [31:0] DATA = onewire_dev_data_addr_c;
  // en=1, prsc=0, clkdiv=4, pres_en=1
  localparam logic [31:0] CFG  = 32'h0000_0821;
  localparam logic [31:0] ARM_RX = 32'h0000_1000;
  localparam logic [31:0] ARM_TX = 32'h0000_2000;
  localparam logic [31:0] CLR_RS = 32'h1000_0000;
  localparam int TK = 5; // cycles per tick

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] data_o;
  logic        ack_o;
  logic        clkgen_en_o;
  logic [7:0]  clkgen = 8'hFF;
  logic        host_low = 1'b0;
  logic        line;
  logic        onewire_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;
  int irq_total = 0;

  assign line = ~host_low & onewire_o;

  always #5 clk = ~clk;

  cellrv32_onewire_dev dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_i      (addr),
    .rden_i      (rden),
    .wren_i      (wren),
    .data_i      (wdata),
    .data_o      (data_o),
    .ack_o       (ack_o),
    .clkgen_en_o (clkgen_en_o),
    .clkgen_i    (clkgen),
    .onewire_i   (line),
    .onewire_o   (onewire_o),
    .irq_o       (irq_o)
  );

  always @(negedge clk) begin
    if (irq_o) irq_total <= irq_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    chk("rd_ack", {31'd0, ack_o}, 32'd1);
    d = data_o;
  endtask

  // host write slot: release at tick 1 for a 1, tick 7 for a 0; slot = 10 ticks
  task automatic host_write_bit(input logic b);
    host_low = 1'b1;
    wait_cyc(b ? 1*TK : 7*TK);
    host_low = 1'b0;
    wait_cyc(b ? 9*TK : 3*TK);
  endtask

  // host read slot: low for 1 tick, sample at tick 2, device must be off by tick 6
  task automatic host_read_bit(output logic b);
    host_low = 1'b1;
    wait_cyc(TK);
    host_low = 1'b0;
    wait_cyc(TK);
    b = line;
    wait_cyc(4*TK);
    chk("tx_release", {31'd0, onewire_o}, 32'd1);
    wait_cyc(4*TK);
  endtask

  // host reset pulse; observes the device presence answer for 20 ticks
  task automatic host_reset(input int ticks, output int low_cnt, output int first_low);
    host_low = 1'b1;
    wait_cyc(ticks*TK);
    chk("rst_hold_rel", {31'd0, onewire_o}, 32'd1);
    host_low = 1'b0;
    low_cnt = 0;
    first_low = -1;
    for (int i = 0; i < 20*TK; i++) begin
      @(negedge clk);
      if (!onewire_o) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
  endtask

  task automatic rx_byte(input logic [7:0] v);
    int base;
    logic [31:0] rd;
    base = irq_total;
    for (int i = 0; i < 7; i++) host_write_bit(v[i]);
    chk("rx_no_early_irq", irq_total - base, 32'd0);
    host_write_bit(v[7]);
    chk("rx_irq", irq_total - base, 32'd1);
    bus_read(DATA, rd);
    chk("rx_data", rd, {24'd0, v});
    bus_read(CTRL, rd);
    chk("rx_ctrl_disarmed", rd, 32'h2000_0821);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  byte_rx;
    logic        b;
    int          base, low_cnt, first_low;

    // ---- reset state ----
    wait_cyc(3);
    chk("rst_data_o", data_o, 32'd0);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_clkgen_en", {31'd0, clkgen_en_o}, 32'd0);
    chk("rst_onewire_o", {31'd0, onewire_o}, 32'd1);
    rst = 1'b0;
    wait_cyc(3);
    bus_read(CTRL, rd);
    chk("ctrl_after_rst", rd, 32'h2000_0000);

    // ---- configure ----
    bus_write(CTRL, CFG);
    chk("clkgen_en_on", {31'd0, clkgen_en_o}, 32'd1);
    bus_read(CTRL, rd);
    chk("ctrl_cfg", rd, 32'h2000_0821);
    wait_cyc(4*TK);

    // ---- reset detection with presence pulse ----
    base = irq_total;
    host_reset(48, low_cnt, first_low);
    chk("pres_len_cycles", low_cnt, 12*TK);
    chk("pres_start_window", (first_low >= 4 && first_low <= 14) ? 32'd1 : 32'd0, 32'd1);
    chk("rst_irq_once", irq_total - base, 32'd1);
    bus_read(CTRL, rd);
    chk("rst_seen_set", rd, 32'h3000_0821);
    bus_write(CTRL, CFG | CLR_RS);
    bus_read(CTRL, rd);
    chk("rst_seen_clr", rd, 32'h2000_0821);

    // ---- byte receive 0xA5 ----
    bus_write(CTRL, CFG | ARM_RX);
    bus_read(CTRL, rd);
    chk("rx_armed", rd, 32'h6000_0821);
    rx_byte(8'hA5);

    // ---- byte transmit 0x3C ----
    bus_write(DATA, 32'h0000_003C);
    bus_write(CTRL, CFG | ARM_TX);
    bus_read(DATA, rd);
    chk("tx_sreg_loaded", rd, 32'h0000_003C);
    base = irq_total;
    byte_rx = 8'd0;
    for (int i = 0; i < 8; i++) begin
      host_read_bit(b);
      byte_rx[i] = b;
    end
    chk("tx_host_byte", {24'd0, byte_rx}, 32'h0000_003C);
    chk("tx_irq", irq_total - base, 32'd1);
    bus_read(CTRL, rd);
    chk("tx_ctrl_disarmed", rd, 32'h2000_0821);

    // ---- reset in mid-transfer ----
    bus_write(CTRL, CFG | ARM_RX);
    base = irq_total;
    for (int i = 0; i < 3; i++) host_write_bit(1'b1);
    host_reset(60, low_cnt, first_low);
    chk("mid_pres_len", low_cnt, 12*TK);
    chk("mid_irq_only_rst", irq_total - base, 32'd1);
    bus_read(CTRL, rd);
    chk("mid_ctrl", rd, 32'h3000_0821);
    // bit counter must be back at 7: a full new byte needs all 8 slots
    bus_write(CTRL, CFG | CLR_RS | ARM_RX);
    rx_byte(8'h5A);

    // ---- arm while busy ----
    host_low = 1'b1;
    wait_cyc(48*TK);
    host_low = 1'b0;
    wait_cyc(5*TK);
    bus_write(CTRL, CFG | ARM_TX);
    bus_read(CTRL, rd);
    chk("busy_arm_ignored", {31'd0, rd[30]}, 32'd0);
    chk("busy_flag", {31'd0, rd[31]}, 32'd1);
    wait_cyc(20*TK);
    bus_write(CTRL, CFG | CLR_RS | ARM_TX);
    bus_read(CTRL, rd);
    chk("retry_armed", rd, 32'h6000_0821);

    // ---- disable in mid-slot while driving a 0 ----
    host_low = 1'b1;
    wait_cyc(TK);
    host_low = 1'b0;
    wait_cyc(3);
    chk("dis_driving", {31'd0, onewire_o}, 32'd0);
    bus_write(CTRL, CFG & ~32'd1);
    chk("dis_released", {31'd0, onewire_o}, 32'd1);
    chk("dis_clkgen_en", {31'd0, clkgen_en_o}, 32'd0);
    bus_read(CTRL, rd);
    chk("dis_ctrl", rd, 32'h2000_0820);
    bus_read(DATA, rd);
    chk("dis_data", rd, 32'd0);

    // ---- asynchronous reset while driving ----
    bus_write(CTRL, CFG);
    wait_cyc(4*TK);
    bus_write(CTRL, CFG | ARM_TX);
    host_low = 1'b1;
    wait_cyc(8);
    chk("ar_driving", {31'd0, onewire_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_released", {31'd0, onewire_o}, 32'd1);
    chk("ar_clkgen_en", {31'd0, clkgen_en_o}, 32'd0);
    host_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(3);
    bus_read(CTRL, rd);
    chk("ar_ctrl", rd, 32'h2000_0000);
    // tx_data must be cleared: arming tx now loads 0 into the shift register
    bus_write(CTRL, CFG);
    wait_cyc(4);
    bus_write(CTRL, CFG | ARM_TX);
    bus_read(DATA, rd);
    chk("ar_tx_data_clr", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp + 1, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
